// File: rtl/fpu_stream_wrapper.sv
// Streaming front end for the fixed-latency fpu core: round-robin request arbiter,
// credit-limited issue, in-flight tracking pipe and in-order result FIFO.
// Optional sticky exception register is enabled by defining FPU_STREAM_STICKY_EN.
module fpu_stream_wrapper #(
  parameter int NUM_CH = 2,
  parameter int LAT    = 4,
  parameter int DEPTH  = 4,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      in_valid,
  output logic [NUM_CH-1:0]      in_ready,
  input  logic [3*NUM_CH-1:0]    in_op,
  input  logic [2*NUM_CH-1:0]    in_rmode,
  input  logic [32*NUM_CH-1:0]   in_opa,
  input  logic [32*NUM_CH-1:0]   in_opb,
  output logic [2:0]             fpu_op,
  output logic [1:0]             rmode,
  output logic [31:0]            opa,
  output logic [31:0]            opb,
  input  logic [31:0]            core_out,
  input  logic [7:0]             core_flags,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [7:0]             res_flags,
  output logic [CW-1:0]          res_ch,
  input  logic                   sticky_clr,
  output logic [7:0]             exc_sticky
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]         wr_q, rd_q, cnt_q, cnt_d;
  logic [CW-1:0]       rr_q, rr_d, gnt_ch;
  logic [NUM_CH-1:0]   grant;
  logic                accept, pop, empty, credit;
  logic [2:0]          sel_op, fpu_op_q;
  logic [1:0]          sel_rm, rmode_q;
  logic [31:0]         sel_a, sel_b, opa_q, opb_q;
  logic [LAT:0]        trk_v_q;
  logic [CW-1:0]       trk_ch_q [LAT+1];
  logic [31:0]         mem_data_q  [DEPTH];
  logic [7:0]          mem_flags_q [DEPTH];
  logic [CW-1:0]       mem_ch_q    [DEPTH];

  assign empty     = (wr_q == rd_q);
  assign res_valid = !empty;
  assign pop       = res_valid & res_ready;
  // a pop in the same cycle frees the credit the new accept consumes
  assign credit    = (cnt_q < (AW+1)'(DEPTH)) || pop;

  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    gnt_ch = '0;
    rr_d   = rr_q;
    sel_op = '0;
    sel_rm = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (grant == '0 && in_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_ch     = CW'(idx);
        rr_d       = (idx == NUM_CH - 1) ? '0 : CW'(idx + 1);
        sel_op     = in_op[3*idx +: 3];
        sel_rm     = in_rmode[2*idx +: 2];
        sel_a      = in_opa[32*idx +: 32];
        sel_b      = in_opb[32*idx +: 32];
      end
    end
    if (rst || !credit) begin
      grant = '0;
      rr_d  = rr_q;
    end
  end

  assign in_ready = grant;
  assign accept   = |grant;

  always_comb begin
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      trk_v_q  <= '0;
      fpu_op_q <= '0;
      rmode_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      for (int i = 0; i <= LAT; i++) trk_ch_q[i] <= '0;
    end else begin
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_q + (AW+1)'(pop);
      wr_q        <= wr_q + (AW+1)'(trk_v_q[LAT]);
      trk_v_q     <= {trk_v_q[LAT-1:0], accept};
      trk_ch_q[0] <= gnt_ch;
      for (int i = 1; i <= LAT; i++) trk_ch_q[i] <= trk_ch_q[i-1];
      if (accept) begin
        fpu_op_q <= sel_op;
        rmode_q  <= sel_rm;
        opa_q    <= sel_a;
        opb_q    <= sel_b;
      end
    end
  end

  // storage needs no reset: reads are masked while the pointers say empty
  always_ff @(posedge clk) begin
    if (trk_v_q[LAT]) begin
      mem_data_q[wr_q[AW-1:0]]  <= core_out;
      mem_flags_q[wr_q[AW-1:0]] <= core_flags;
      mem_ch_q[wr_q[AW-1:0]]    <= trk_ch_q[LAT];
    end
  end

  assign fpu_op    = fpu_op_q;
  assign rmode     = rmode_q;
  assign opa       = opa_q;
  assign opb       = opb_q;
  assign res_data  = empty ? '0 : mem_data_q[rd_q[AW-1:0]];
  assign res_flags = empty ? '0 : mem_flags_q[rd_q[AW-1:0]];
  assign res_ch    = empty ? '0 : mem_ch_q[rd_q[AW-1:0]];

`ifdef FPU_STREAM_STICKY_EN
  logic [7:0] sticky_q;

  // a clear in the same cycle as a pop keeps only that pop's flags
  always_ff @(posedge clk) begin
    if (rst)             sticky_q <= '0;
    else if (sticky_clr) sticky_q <= pop ? res_flags : 8'h00;
    else if (pop)        sticky_q <= sticky_q | res_flags;
  end

  assign exc_sticky = sticky_q;
`else
  logic sticky_clr_unused;

  assign sticky_clr_unused = sticky_clr;
  assign exc_sticky        = 8'h00;
`endif

endmodule
